// File: rtl/bgpu_reg_arb_pkg.sv
// Shared configuration, types and bank-mapping helpers for the register-file bank arbiter.
package bgpu_reg_arb_pkg;

  localparam int unsigned NumCollectors   = 2;
  localparam int unsigned OperandsPerInst = 3;
  localparam int unsigned NumBanks        = 4;
  localparam int unsigned NumWarps        = 8;
  localparam int unsigned RegIdxWidth     = 6;
  localparam int unsigned WarpWidth       = 8;
  localparam int unsigned RegWidth        = 4;

  localparam int unsigned NumReq       = NumCollectors * OperandsPerInst;
  localparam int unsigned WidWidth     = (NumWarps > 1) ? $clog2(NumWarps) : 1;
  localparam int unsigned DataWidth    = RegWidth * WarpWidth;
  localparam int unsigned BankSelWidth = $clog2(NumBanks);
  localparam int unsigned AddrWidth    = WidWidth + RegIdxWidth - BankSelWidth;
  localparam int unsigned ReqIdWidth   = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef logic [WidWidth-1:0]     wid_t;
  typedef logic [RegIdxWidth-1:0]  reg_idx_t;
  typedef logic [DataWidth-1:0]    data_t;
  typedef logic [BankSelWidth-1:0] bank_idx_t;
  typedef logic [AddrWidth-1:0]    bank_addr_t;
  typedef logic [ReqIdWidth-1:0]   req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } grant_t;

  // Skewing by wid spreads the same register of different warps across banks.
  function automatic bank_idx_t bank_of(input wid_t wid, input reg_idx_t reg_idx);
    return bank_idx_t'(wid) + bank_idx_t'(reg_idx);
  endfunction

  function automatic bank_addr_t addr_of(input wid_t wid, input reg_idx_t reg_idx);
    return {wid, reg_idx[RegIdxWidth-1:BankSelWidth]};
  endfunction

endpackage

// File: rtl/rr_bank_arbiter.sv
// Single-bank round-robin arbiter over all read requesters, with its own priority pointer.
module rr_bank_arbiter
  import bgpu_reg_arb_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] gnt_o,
  output req_id_t           winner_o,
  output logic              valid_o
);

  req_id_t ptr_q, ptr_d;

  // Two passes: first the requesters at or above the pointer, then the wrapped-around ones.
  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    gnt_o    = '0;
    for (int unsigned j = 0; j < NumReq; j++) begin
      if (!valid_o && req_i[j] && (j >= 32'(ptr_q))) begin
        valid_o  = 1'b1;
        winner_o = req_id_t'(j);
        gnt_o[j] = 1'b1;
      end
    end
    for (int unsigned j = 0; j < NumReq; j++) begin
      if (!valid_o && req_i[j] && (j < 32'(ptr_q))) begin
        valid_o  = 1'b1;
        winner_o = req_id_t'(j);
        gnt_o[j] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (valid_o) begin
      ptr_d = (winner_o == req_id_t'(NumReq - 1)) ? '0 : winner_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/register_bank_arbiter.sv
// Arbitrates operand-collector reads onto the banked register file and routes data back.
// Optional conflict counter enabled by defining BGPU_REG_BANK_ARB_PERF_EN.
module register_bank_arbiter
  import bgpu_reg_arb_pkg::*;
(
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumReq-1:0]                     req_valid_i,
  output logic [NumReq-1:0]                     req_ready_o,
  input  logic [NumReq-1:0][WidWidth-1:0]       req_wid_i,
  input  logic [NumReq-1:0][RegIdxWidth-1:0]    req_reg_idx_i,
  output logic [NumReq-1:0]                     rsp_valid_o,
  output logic [NumReq-1:0][DataWidth-1:0]      rsp_data_o,
  output logic [NumBanks-1:0]                   bank_req_valid_o,
  output logic [NumBanks-1:0][AddrWidth-1:0]    bank_addr_o,
  input  logic [NumBanks-1:0][DataWidth-1:0]    bank_rdata_i
`ifdef BGPU_REG_BANK_ARB_PERF_EN
  ,
  output logic [31:0]                           conflict_cnt_o
`endif
);

  bank_idx_t  [NumReq-1:0]               req_bank;
  bank_addr_t [NumReq-1:0]               req_addr;
  logic       [NumBanks-1:0][NumReq-1:0] cand;
  logic       [NumBanks-1:0][NumReq-1:0] bank_gnt;
  req_id_t    [NumBanks-1:0]             bank_winner;
  logic       [NumBanks-1:0]             bank_valid;
  grant_t     [NumBanks-1:0]             grant_q, grant_d;

  // Candidates are masked during reset so no grant or bank read can escape.
  always_comb begin
    cand = '0;
    for (int unsigned r = 0; r < NumReq; r++) begin
      req_bank[r] = bank_of(req_wid_i[r], req_reg_idx_i[r]);
      req_addr[r] = addr_of(req_wid_i[r], req_reg_idx_i[r]);
      for (int unsigned b = 0; b < NumBanks; b++) begin
        cand[b][r] = req_valid_i[r] && !rst_i && (req_bank[r] == bank_idx_t'(b));
      end
    end
  end

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    rr_bank_arbiter u_arb (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .req_i    (cand[b]),
      .gnt_o    (bank_gnt[b]),
      .winner_o (bank_winner[b]),
      .valid_o  (bank_valid[b])
    );
  end

  always_comb begin
    req_ready_o      = '0;
    bank_req_valid_o = '0;
    bank_addr_o      = '0;
    rsp_valid_o      = '0;
    rsp_data_o       = '0;
    for (int unsigned b = 0; b < NumBanks; b++) begin
      req_ready_o         = req_ready_o | bank_gnt[b];
      bank_req_valid_o[b] = bank_valid[b];
      if (bank_valid[b]) begin
        bank_addr_o[b] = req_addr[bank_winner[b]];
      end
      grant_d[b].valid = bank_valid[b];
      grant_d[b].id    = bank_winner[b];
      // A requester wins at most one bank per cycle, so these writes never overlap.
      if (grant_q[b].valid && !rst_i) begin
        rsp_valid_o[grant_q[b].id] = 1'b1;
        rsp_data_o[grant_q[b].id]  = bank_rdata_i[b];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_q <= '0;
    end else begin
      grant_q <= grant_d;
    end
  end

`ifdef BGPU_REG_BANK_ARB_PERF_EN
  logic [31:0]         conflict_cnt_q, conflict_cnt_d;
  logic [ReqIdWidth:0] lose_cnt;
  logic [32:0]         cnt_sum;

  always_comb begin
    lose_cnt = '0;
    for (int unsigned r = 0; r < NumReq; r++) begin
      lose_cnt = lose_cnt + {{ReqIdWidth{1'b0}}, (req_valid_i[r] & ~req_ready_o[r])};
    end
    cnt_sum        = {1'b0, conflict_cnt_q} + {{(32 - ReqIdWidth){1'b0}}, lose_cnt};
    conflict_cnt_d = cnt_sum[32] ? '1 : cnt_sum[31:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conflict_cnt_q <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign conflict_cnt_o = conflict_cnt_q;
`endif

`ifndef SYNTHESIS
  for (genvar r = 0; r < NumReq; r++) begin : g_req_stable
    a_req_stable : assert property (@(posedge clk_i) disable iff (rst_i)
      (req_valid_i[r] && !req_ready_o[r]) |=>
      (req_valid_i[r] && $stable(req_wid_i[r]) && $stable(req_reg_idx_i[r])));
  end
`endif

endmodule

// File: tb/tb_register_bank_arbiter.sv
// Scoreboard bench for register_bank_arbiter; a bank SRAM model serves reads from a golden map.
module tb_register_bank_arbiter;
  import bgpu_reg_arb_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [NumReq-1:0]                  req_valid = '1;
  logic [NumReq-1:0]                  req_ready;
  logic [NumReq-1:0][WidWidth-1:0]    req_wid   = '0;
  logic [NumReq-1:0][RegIdxWidth-1:0] req_reg   = '0;
  logic [NumReq-1:0]                  rsp_valid;
  logic [NumReq-1:0][DataWidth-1:0]   rsp_data;
  logic [NumBanks-1:0]                bank_valid;
  logic [NumBanks-1:0][AddrWidth-1:0] bank_addr;
  logic [NumBanks-1:0][DataWidth-1:0] bank_rdata = '0;
`ifdef BGPU_REG_BANK_ARB_PERF_EN
  logic [31:0] conflict_cnt;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;

  register_bank_arbiter dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_wid_i        (req_wid),
    .req_reg_idx_i    (req_reg),
    .rsp_valid_o      (rsp_valid),
    .rsp_data_o       (rsp_data),
    .bank_req_valid_o (bank_valid),
    .bank_addr_o      (bank_addr),
    .bank_rdata_i     (bank_rdata)
`ifdef BGPU_REG_BANK_ARB_PERF_EN
    ,
    .conflict_cnt_o   (conflict_cnt)
`endif
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  function automatic data_t golden(input wid_t w, input reg_idx_t r);
    logic [31:0] h;
    h = (32'({w, r}) * 32'h9E37_79B1) ^ 32'hA5C3_0F1E;
    return data_t'(h);
  endfunction

  // Bank SRAM model: recovers (wid, reg) from bank number and row, answers one cycle later.
  logic [NumBanks-1:0]                pend_v;
  logic [NumBanks-1:0][AddrWidth-1:0] pend_a;
  always @(negedge clk_i) begin
    pend_v = bank_valid;
    pend_a = bank_addr;
  end
  always @(posedge clk_i) begin
    wid_t w;
    reg_idx_t rg;
    bank_idx_t lo;
    #2;
    for (int b = 0; b < NumBanks; b++) begin
      if (pend_v[b] === 1'b1) begin
        w  = pend_a[b][AddrWidth-1 -: WidWidth];
        lo = bank_idx_t'(b) - bank_idx_t'(w);
        rg = {pend_a[b][AddrWidth-WidWidth-1:0], lo};
        bank_rdata[b] = golden(w, rg);
      end else begin
        bank_rdata[b] = data_t'($urandom);
      end
    end
  end

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [31:0]          cyc;
  } exp_t;
  exp_t exp_q[NumReq][$];

  always @(negedge clk_i) begin
    exp_t e;
    if (rst_i) begin
      checks++;
      if (req_ready !== '0 || rsp_valid !== '0 || bank_valid !== '0) begin
        errors++;
        $display("FAIL reset_outputs ready=%b rsp_valid=%b bank_valid=%b required all zero",
                 req_ready, rsp_valid, bank_valid);
      end
      for (int r = 0; r < NumReq; r++) exp_q[r].delete();
    end else begin
      for (int r = 0; r < NumReq; r++) begin
        checks++;
        if (rsp_valid[r] === 1'b1) begin
          if (exp_q[r].size() == 0) begin
            errors++;
            $display("FAIL rsp_spurious r%0d data=%h required no response", r, rsp_data[r]);
          end else begin
            e = exp_q[r].pop_front();
            if (rsp_data[r] !== e.data || e.cyc != cyc - 1) begin
              errors++;
              $display("FAIL rsp_data r%0d got=%h required=%h (issued cyc %0d, now %0d)",
                       r, rsp_data[r], e.data, e.cyc, cyc);
            end
          end
        end else if (exp_q[r].size() != 0) begin
          errors++;
          e = exp_q[r].pop_front();
          $display("FAIL rsp_missing r%0d rsp_valid=%b required=1 data=%h", r, rsp_valid[r],
                   e.data);
        end else if (rsp_data[r] !== '0) begin
          errors++;
          $display("FAIL rsp_data_idle r%0d got=%h required=0", r, rsp_data[r]);
        end
        checks++;
        if (req_ready[r] === 1'b1 && req_valid[r] !== 1'b1) begin
          errors++;
          $display("FAIL ready_without_valid r%0d ready=1 required=0", r);
        end
        if (req_valid[r] && req_ready[r] === 1'b1) begin
          exp_q[r].push_back('{data: golden(req_wid[r], req_reg[r]), cyc: cyc});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst_i     = 1'b1;
    req_valid = '0;
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if (req_ready !== '0 || bank_addr !== '0 || rsp_data !== '0) begin
      errors++;
      $display("FAIL reset_hold ready=%b addr=%h rsp_data=%h required 0", req_ready, bank_addr,
               rsp_data);
    end
`ifdef BGPU_REG_BANK_ARB_PERF_EN
    checks++;
    if (conflict_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_cnt got=%0d required=0", conflict_cnt);
    end
`endif
    step();
    rst_i     = 1'b0;
    req_valid = '0;
    @(negedge clk_i);
    checks++;
    if (req_ready !== '0 || bank_valid !== '0 || rsp_valid !== '0) begin
      errors++;
      $display("FAIL post_reset ready=%b bank_valid=%b rsp_valid=%b required 0", req_ready,
               bank_valid, rsp_valid);
    end
  endtask

  task automatic test_single();
    do_reset();
    step();
    req_wid[0] = 3'd1;
    req_reg[0] = 6'd2;
    req_valid  = 6'b000001;
    @(negedge clk_i);
    checks++;
    if (req_ready !== 6'b000001 || bank_valid !== 4'b1000 || bank_addr[3] !== 7'd16) begin
      errors++;
      $display("FAIL single_req ready=%b bank_valid=%b addr3=%0d required 000001 1000 16",
               req_ready, bank_valid, bank_addr[3]);
    end
    step();
    req_valid = '0;
    @(negedge clk_i);
    checks++;
    if (rsp_valid !== 6'b000001 || rsp_data[0] !== golden(3'd1, 6'd2)) begin
      errors++;
      $display("FAIL single_rsp valid=%b data=%h required 000001 %h", rsp_valid, rsp_data[0],
               golden(3'd1, 6'd2));
    end
  endtask

  task automatic test_conflict();
    int unsigned seq[4] = '{1, 4, 1, 4};
    logic [NumReq-1:0] exp_rdy;
    do_reset();
    step();
    req_wid[1] = 3'd0;
    req_reg[1] = 6'd0;
    req_wid[4] = 3'd0;
    req_reg[4] = 6'd4;
    req_valid  = 6'b010010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      exp_rdy          = '0;
      exp_rdy[seq[k]]  = 1'b1;
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++;
        $display("FAIL conflict_grant k=%0d got=%b required=%b", k, req_ready, exp_rdy);
      end
`ifdef BGPU_REG_BANK_ARB_PERF_EN
      if (k == 2) begin
        checks++;
        if (conflict_cnt !== 32'd2) begin
          errors++;
          $display("FAIL conflict_cnt got=%0d required=2", conflict_cnt);
        end
      end
`endif
      step();
    end
    req_valid = 6'b000010;
    @(negedge clk_i);
    checks++;
    if (req_ready !== 6'b000010) begin
      errors++;
      $display("FAIL conflict_drain got=%b required=000010", req_ready);
    end
`ifdef BGPU_REG_BANK_ARB_PERF_EN
    checks++;
    if (conflict_cnt !== 32'd4) begin
      errors++;
      $display("FAIL conflict_cnt4 got=%0d required=4", conflict_cnt);
    end
`endif
    step();
    req_valid = '0;
  endtask

  task automatic test_parallel();
    do_reset();
    step();
    for (int r = 0; r < 4; r++) begin
      req_wid[r] = wid_t'(r + 1);
      req_reg[r] = reg_idx_t'(4 * r + 3);
    end
    req_valid = 6'b001111;
    @(negedge clk_i);
    checks++;
    if (req_ready !== 6'b001111 || bank_valid !== 4'b1111) begin
      errors++;
      $display("FAIL parallel_grant ready=%b bank_valid=%b required 001111 1111", req_ready,
               bank_valid);
    end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (bank_addr[b] !== 7'((b + 1) * 16 + b)) begin
        errors++;
        $display("FAIL parallel_addr b%0d got=%0d required=%0d", b, bank_addr[b],
                 (b + 1) * 16 + b);
      end
    end
    step();
    req_valid = '0;
    @(negedge clk_i);
    checks++;
    if (rsp_valid !== 6'b001111) begin
      errors++;
      $display("FAIL parallel_rsp valid=%b required=001111", rsp_valid);
    end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (rsp_data[r] !== golden(wid_t'(r + 1), reg_idx_t'(4 * r + 3))) begin
        errors++;
        $display("FAIL parallel_data r%0d got=%h required=%h", r, rsp_data[r],
                 golden(wid_t'(r + 1), reg_idx_t'(4 * r + 3)));
      end
    end
  endtask

  task automatic test_wrap();
    int unsigned seq[3] = '{5, 0, 5};
    logic [NumReq-1:0] exp_rdy;
    do_reset();
    step();
    req_wid[4] = 3'd0;
    req_reg[4] = 6'd2;
    req_valid  = 6'b010000;
    @(negedge clk_i);
    checks++;
    if (req_ready !== 6'b010000) begin
      errors++;
      $display("FAIL wrap_setup got=%b required=010000", req_ready);
    end
    step();
    req_wid[5] = 3'd1;
    req_reg[5] = 6'd1;
    req_wid[0] = 3'd2;
    req_reg[0] = 6'd0;
    req_valid  = 6'b100001;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      exp_rdy         = '0;
      exp_rdy[seq[k]] = 1'b1;
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++;
        $display("FAIL wrap_grant k=%0d got=%b required=%b", k, req_ready, exp_rdy);
      end
      step();
    end
    req_valid = 6'b000001;
    @(negedge clk_i);
    step();
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    step();
    req_wid[1] = 3'd0;
    req_reg[1] = 6'd1;
    req_valid  = 6'b000010;
    @(negedge clk_i);
    checks++;
    if (req_ready !== 6'b000010) begin
      errors++;
      $display("FAIL rmid_grant got=%b required=000010", req_ready);
    end
    step();
    rst_i      = 1'b1;
    req_wid[3] = 3'd0;
    req_reg[3] = 6'd5;
    req_valid  = 6'b001010;
    @(negedge clk_i);
    checks++;
    if (rsp_valid !== '0 || req_ready !== '0) begin
      errors++;
      $display("FAIL rmid_drop rsp_valid=%b ready=%b required 0 0", rsp_valid, req_ready);
    end
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (req_ready !== 6'b000010 || rsp_valid !== '0) begin
      errors++;
      $display("FAIL rmid_first ready=%b rsp_valid=%b required 000010 0", req_ready, rsp_valid);
    end
    step();
    req_valid = 6'b001000;
    @(negedge clk_i);
    checks++;
    if (req_ready !== 6'b001000 || rsp_valid !== 6'b000010) begin
      errors++;
      $display("FAIL rmid_next ready=%b rsp_valid=%b required 001000 000010", req_ready,
               rsp_valid);
    end
    step();
    req_valid = '0;
  endtask

  task automatic test_stress();
    logic [NumReq-1:0] hs = '0;
    int unsigned wait_cnt[NumReq];
    int unsigned max_wait = 0;
    int unsigned pending;
    do_reset();
    for (int r = 0; r < NumReq; r++) wait_cnt[r] = 0;
    for (int n = 0; n < 10000; n++) begin
      step();
      for (int r = 0; r < NumReq; r++) begin
        if (!req_valid[r] || hs[r]) begin
          req_valid[r] = ($urandom_range(0, 3) != 0);
          req_wid[r]   = wid_t'($urandom);
          req_reg[r]   = reg_idx_t'($urandom);
        end
      end
      @(negedge clk_i);
      hs = req_valid & req_ready;
      for (int r = 0; r < NumReq; r++) begin
        wait_cnt[r] = (req_valid[r] && !req_ready[r]) ? wait_cnt[r] + 1 : 0;
        if (wait_cnt[r] > max_wait) max_wait = wait_cnt[r];
      end
    end
    for (int n = 0; n < 2 * NumReq && req_valid != '0; n++) begin
      step();
      req_valid = req_valid & ~hs;
      @(negedge clk_i);
      hs = req_valid & req_ready;
    end
    step();
    req_valid = '0;
    @(negedge clk_i);
    step();
    @(negedge clk_i);
    pending = 0;
    for (int r = 0; r < NumReq; r++) pending += exp_q[r].size();
    checks++;
    if (pending != 0) begin
      errors++;
      $display("FAIL stress_drain outstanding=%0d required=0", pending);
    end
    checks++;
    if (max_wait > NumReq - 1) begin
      errors++;
      $display("FAIL stress_fairness max_wait=%0d required<=%0d", max_wait, NumReq - 1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_conflict();
    test_parallel();
    test_wrap();
    test_reset_mid();
    test_stress();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
